// File: rtl/priority_resolver_isr_pkg.sv
// Shared definitions for the interrupt priority resolver / in-service logic.
// Contents: level count, spurious level, FSM state encoding, OCW2 {R,SL,EOI}
// command codes and a priority-rank helper used for fully nested comparison.
package pic_pkg;

  localparam int         NUM_IR     = 8;
  localparam logic [2:0] SPUR_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    VEC  = 2'd2
  } state_t;

  // OCW2 {R, SL, EOI}
  localparam logic [2:0] OCW2_AEOI_ROT_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_AEOI_ROT_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // Rank 0 is the highest priority: the level just after lowest_prio.
  function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                           input logic [2:0] lowest);
    return level - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver_isr_if.sv
// Bus bundle between the PIC front end (IRR/IMR/command registers) and the
// priority resolver / ISR block.
//   master: drives irr, imr, inta_pulse, eoi_strobe, ocw2_rsl, ocw2_level,
//           aeoi_mode, vector_base; receives int_req, isr, clr_irr,
//           vector_out, vector_valid.
//   slave : the resolver (opposite directions).
interface priority_resolver_isr_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_pulse;
  logic       eoi_strobe;
  logic [2:0] ocw2_rsl;
  logic [2:0] ocw2_level;
  logic       aeoi_mode;
  logic [4:0] vector_base;
  logic       int_req;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [7:0] vector_out;
  logic       vector_valid;

  modport master (
    output irr, imr, inta_pulse, eoi_strobe, ocw2_rsl, ocw2_level,
           aeoi_mode, vector_base,
    input  int_req, isr, clr_irr, vector_out, vector_valid
  );

  modport slave (
    input  irr, imr, inta_pulse, eoi_strobe, ocw2_rsl, ocw2_level,
           aeoi_mode, vector_base,
    output int_req, isr, clr_irr, vector_out, vector_valid
  );
endinterface

// File: rtl/priority_resolver_isr_rot_prio_enc.sv
// Rotating 8-bit priority encoder.
// Ports: vec (request bits), lowest_prio (level with lowest priority; search
// starts one above it and wraps) -> level (winning bit index), found.
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lowest_prio,
  output logic [2:0] level,
  output logic       found
);

  logic [2:0] idx;

  // Walk from lowest priority to highest so the last hit is the winner.
  always_comb begin
    level = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = lowest_prio + 3'(i) + 3'd1;
      if (vec[idx]) begin
        level = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_resolver_isr.sv
// Priority resolver and In-Service Register for an 8259-style PIC.
// Ports: clk, rst (sync, active high), bus (slave modport): pending requests
// and mask in, INT/ISR/IRR-clear/vector out, OCW2 command strobe in.
//
// state | meaning
// IDLE  | waiting for first INTA; int_req evaluated here
// ACK1  | first INTA taken, level frozen, waiting for second INTA
// VEC   | vector strobed out; AEOI clear/rotate applied on exit
module priority_resolver_isr
  import pic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  priority_resolver_isr_if.slave  bus
);

  state_t     state_q, state_d;
  logic [2:0] lvl_q;
  logic       spur_q;
  logic [2:0] lowest_prio_q, lowest_prio_d;
  logic       aeoi_rotate_q, aeoi_rotate_d;
  logic [7:0] isr_q, isr_d, isr_set, isr_clr;
  logic       int_req_q;
  logic [7:0] clr_irr_q;
  logic [7:0] vector_out_q;
  logic       vector_valid_q;

  logic [7:0] req;
  logic [2:0] cand_lvl, top_lvl;
  logic       cand_found, top_found, cand_wins;
  logic       inta_first, inta_second, vec_exit;

  assign req = bus.irr & ~bus.imr;

  pic_rot_prio_enc u_cand_enc (
    .vec         (req),
    .lowest_prio (lowest_prio_q),
    .level       (cand_lvl),
    .found       (cand_found)
  );

  pic_rot_prio_enc u_isr_enc (
    .vec         (isr_q),
    .lowest_prio (lowest_prio_q),
    .level       (top_lvl),
    .found       (top_found)
  );

  // Fully nested: a request only interrupts if it outranks everything in service.
  assign cand_wins = cand_found &&
                     (!top_found ||
                      (prio_rank(cand_lvl, lowest_prio_q) < prio_rank(top_lvl, lowest_prio_q)));

  always_comb begin
    state_d     = state_q;
    inta_first  = 1'b0;
    inta_second = 1'b0;
    vec_exit    = 1'b0;
    case (state_q)
      IDLE: if (bus.inta_pulse) begin
        state_d    = ACK1;
        inta_first = 1'b1;
      end
      ACK1: if (bus.inta_pulse) begin
        state_d     = VEC;
        inta_second = 1'b1;
      end
      VEC: begin
        state_d  = IDLE;
        vec_exit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // ISR / rotation updates. EOI decodes against the pre-cycle ISR and is applied
  // after AEOI so an explicit command wins a rotation conflict; sets win over clears.
  always_comb begin
    isr_clr       = '0;
    isr_set       = '0;
    lowest_prio_d = lowest_prio_q;
    aeoi_rotate_d = aeoi_rotate_q;

    if (inta_first && cand_found) isr_set = 8'(1) << cand_lvl;

    if (vec_exit && bus.aeoi_mode && !spur_q) begin
      isr_clr[lvl_q] = 1'b1;
      if (aeoi_rotate_q) lowest_prio_d = lvl_q;
    end

    if (bus.eoi_strobe) begin
      case (bus.ocw2_rsl)
        OCW2_NS_EOI:       if (top_found) isr_clr[top_lvl] = 1'b1;
        OCW2_SP_EOI:       isr_clr[bus.ocw2_level] = 1'b1;
        OCW2_ROT_NS_EOI:   if (top_found) begin
          isr_clr[top_lvl] = 1'b1;
          lowest_prio_d    = top_lvl;
        end
        OCW2_ROT_SP_EOI: begin
          isr_clr[bus.ocw2_level] = 1'b1;
          lowest_prio_d           = bus.ocw2_level;
        end
        OCW2_SET_PRIO:     lowest_prio_d = bus.ocw2_level;
        OCW2_AEOI_ROT_SET: aeoi_rotate_d = 1'b1;
        OCW2_AEOI_ROT_CLR: aeoi_rotate_d = 1'b0;
        default: ;
      endcase
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      lvl_q          <= '0;
      spur_q         <= 1'b0;
      lowest_prio_q  <= 3'd7;
      aeoi_rotate_q  <= 1'b0;
      isr_q          <= '0;
      int_req_q      <= 1'b0;
      clr_irr_q      <= '0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      isr_q          <= isr_d;
      lowest_prio_q  <= lowest_prio_d;
      aeoi_rotate_q  <= aeoi_rotate_d;
      int_req_q      <= (state_q == IDLE) && !bus.inta_pulse && cand_wins;
      clr_irr_q      <= isr_set;
      vector_valid_q <= inta_second;
      if (inta_first) begin
        lvl_q  <= cand_found ? cand_lvl : SPUR_LEVEL;
        spur_q <= !cand_found;
      end
      if (inta_second) vector_out_q <= {bus.vector_base, lvl_q};
    end
  end

  assign bus.int_req      = int_req_q;
  assign bus.isr          = isr_q;
  assign bus.clr_irr      = clr_irr_q;
  assign bus.vector_out   = vector_out_q;
  assign bus.vector_valid = vector_valid_q;

endmodule
